// File: rtl/conv_narrow_wide.sv
// conv_narrow_wide: packs RATIO IN_W-bit beats into a held OUT_W-bit word; strobe/err one clk_4f after the last sampled beat.
// No backpressure (in_valid only); `define CONV_FLUSH_EN adds flush and out_keep for zero-padded partial words.
module conv_narrow_wide #(
  parameter int IN_W      = 8,
  parameter int RATIO     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clk_4f,
  input  logic                  reset,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  in_valid,
`ifdef CONV_FLUSH_EN
  input  logic                  flush,
  output logic [RATIO-1:0]      out_keep,
`endif
  output logic [IN_W*RATIO-1:0] out_data,
  output logic                  out_strobe,
  output logic                  out_valid,
  output logic                  err_partial
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int CW    = $clog2(RATIO);
  localparam int IW    = $clog2(RATIO) + 1;
  localparam logic [CW-1:0] LAST     = CW'(RATIO - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(RATIO - 1);

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OUT_W-1:0] asm_q, asm_d;
  logic [OUT_W-1:0] beat_word;
  logic             done_q, done_d;
  logic             drop_q, drop_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_strobe_q, out_strobe_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;
  logic [IW-1:0]    idle_q, idle_d;
`ifdef CONV_FLUSH_EN
  logic             flush_q, flush_d;
  logic [RATIO-1:0] keep_pend_q, keep_pend_d;
  logic [RATIO-1:0] keep_q, keep_d;

  function automatic logic [RATIO-1:0] keep_mask(input logic [CW-1:0] n);
    logic [RATIO-1:0] m;
    for (int k = 0; k < RATIO; k++) m[k] = (CW'(k) < n);
    return m;
  endfunction
`endif

  function automatic int slot_lo(input int k);
    return MSB_FIRST ? OUT_W - (k + 1) * IN_W : k * IN_W;
  endfunction

  // Incoming beat placed at the slot selected by the current count.
  always_comb begin
    beat_word = '0;
    for (int k = 0; k < RATIO; k++)
      if (cnt_q == CW'(k)) beat_word[slot_lo(k) +: IN_W] = in_data;
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      asm_q        <= '0;
      done_q       <= 1'b0;
      drop_q       <= 1'b0;
      out_data_q   <= '0;
      out_strobe_q <= 1'b0;
      out_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      idle_q       <= '0;
`ifdef CONV_FLUSH_EN
      flush_q      <= 1'b0;
      keep_pend_q  <= '0;
      keep_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      asm_q        <= asm_d;
      done_q       <= done_d;
      drop_q       <= drop_d;
      out_data_q   <= out_data_d;
      out_strobe_q <= out_strobe_d;
      out_valid_q  <= out_valid_d;
      err_q        <= err_d;
      idle_q       <= idle_d;
`ifdef CONV_FLUSH_EN
      flush_q      <= flush_d;
      keep_pend_q  <= keep_pend_d;
      keep_q       <= keep_d;
`endif
    end
  end

  // Next state; completion/discard events are registered here and surface one cycle later.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    done_d  = 1'b0;
    drop_d  = 1'b0;
`ifdef CONV_FLUSH_EN
    flush_d     = 1'b0;
    keep_pend_d = keep_pend_q;
`endif
    if (in_valid) asm_d = ((cnt_q == '0) ? '0 : asm_q) | beat_word;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_FILL;
          cnt_d   = CW'(1);
        end
      end
      S_FILL: begin
        if (in_valid) begin
          if (cnt_q == LAST) begin
            done_d = 1'b1;
            cnt_d  = '0;
          end
`ifdef CONV_FLUSH_EN
          else if (flush && cnt_q != '0) begin
            flush_d     = 1'b1;
            keep_pend_d = keep_mask(cnt_q + 1'b1);
            cnt_d       = '0;
            state_d     = S_IDLE;
          end
`endif
          else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (cnt_q != '0) begin
          cnt_d   = '0;
          state_d = S_IDLE;
`ifdef CONV_FLUSH_EN
          if (flush) begin
            flush_d     = 1'b1;
            keep_pend_d = keep_mask(cnt_q);
          end else begin
            drop_d = 1'b1;
          end
`else
          drop_d = 1'b1;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output registers: hold the last word, pulse strobe/err, track stream activity.
  always_comb begin
`ifdef CONV_FLUSH_EN
    out_strobe_d = done_q | flush_q;
    keep_d       = done_q ? '1 : (flush_q ? keep_pend_q : keep_q);
`else
    out_strobe_d = done_q;
`endif
    err_d       = drop_q;
    out_data_d  = out_strobe_d ? asm_q : out_data_q;
    out_valid_d = out_valid_q;
    idle_d      = idle_q;
    if (out_strobe_d) begin
      out_valid_d = 1'b1;
      idle_d      = '0;
    end else if (out_valid_q) begin
      if (idle_q == IDLE_MAX) begin
        out_valid_d = 1'b0;
        idle_d      = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  assign out_data    = out_data_q;
  assign out_strobe  = out_strobe_q;
  assign out_valid   = out_valid_q;
  assign err_partial = err_q;
`ifdef CONV_FLUSH_EN
  assign out_keep    = keep_q;
`endif

endmodule

// File: tb/tb_conv_narrow_wide.sv
// Scoreboard bench for conv_narrow_wide: u0 MSB-first 8x4, u1 LSB-first 8x4, u2 MSB-first 4x8.
module tb_conv_narrow_wide;

  logic        clk_4f = 1'b0;
  logic        reset;
  logic [7:0]  d0;
  logic        v0, fl0;
  logic [3:0]  d2;
  logic        v2, fl2;
  logic [31:0] o0_data, o1_data, o2_data;
  logic        o0_stb, o1_stb, o2_stb;
  logic        o0_vld, o1_vld, o2_vld;
  logic        o0_err, o1_err, o2_err;
  logic [7:0]  k0, k1, k2;

  typedef struct {
    logic        is_err;
    logic [31:0] data;
    logic [7:0]  keep;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk_4f = ~clk_4f;

`ifdef CONV_FLUSH_EN
  logic [3:0] o0_keep, o1_keep;
  logic [7:0] o2_keep;
  assign k0 = {4'h0, o0_keep};
  assign k1 = {4'h0, o1_keep};
  assign k2 = o2_keep;
  conv_narrow_wide u0 (.clk_4f(clk_4f), .reset(reset), .in_data(d0), .in_valid(v0), .flush(fl0),
    .out_keep(o0_keep), .out_data(o0_data), .out_strobe(o0_stb), .out_valid(o0_vld), .err_partial(o0_err));
  conv_narrow_wide #(.MSB_FIRST(1'b0)) u1 (.clk_4f(clk_4f), .reset(reset), .in_data(d0), .in_valid(v0), .flush(fl0),
    .out_keep(o1_keep), .out_data(o1_data), .out_strobe(o1_stb), .out_valid(o1_vld), .err_partial(o1_err));
  conv_narrow_wide #(.IN_W(4), .RATIO(8)) u2 (.clk_4f(clk_4f), .reset(reset), .in_data(d2), .in_valid(v2), .flush(fl2),
    .out_keep(o2_keep), .out_data(o2_data), .out_strobe(o2_stb), .out_valid(o2_vld), .err_partial(o2_err));
`else
  assign k0 = 8'h0;
  assign k1 = 8'h0;
  assign k2 = 8'h0;
  conv_narrow_wide u0 (.clk_4f(clk_4f), .reset(reset), .in_data(d0), .in_valid(v0),
    .out_data(o0_data), .out_strobe(o0_stb), .out_valid(o0_vld), .err_partial(o0_err));
  conv_narrow_wide #(.MSB_FIRST(1'b0)) u1 (.clk_4f(clk_4f), .reset(reset), .in_data(d0), .in_valid(v0),
    .out_data(o1_data), .out_strobe(o1_stb), .out_valid(o1_vld), .err_partial(o1_err));
  conv_narrow_wide #(.IN_W(4), .RATIO(8)) u2 (.clk_4f(clk_4f), .reset(reset), .in_data(d2), .in_valid(v2),
    .out_data(o2_data), .out_strobe(o2_stb), .out_valid(o2_vld), .err_partial(o2_err));
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic judge(input string nm, input logic stb, input logic err,
                       input logic [31:0] data, input logic [7:0] keep, input exp_t e);
    chk1({nm, "_both"}, stb & err, 1'b0);
    chk1({nm, "_kind"}, err, e.is_err);
    chk({nm, "_data"}, data, e.data);
`ifdef CONV_FLUSH_EN
    if (!e.is_err) chk({nm, "_keep"}, {24'h0, keep}, {24'h0, e.keep});
`endif
  endtask

  task automatic unexpected(input string nm, input logic stb, input logic err);
    total++;
    bad++;
    $display("FAIL %s_unexpected: got stb=%b err=%b want no event", nm, stb, err);
  endtask

  always @(negedge clk_4f) begin : mon0
    exp_t e;
    if (!reset && (o0_stb || o0_err)) begin
      if (q0.size() == 0) unexpected("u0", o0_stb, o0_err);
      else begin e = q0.pop_front(); judge("u0", o0_stb, o0_err, o0_data, k0, e); end
    end
  end

  always @(negedge clk_4f) begin : mon1
    exp_t e;
    if (!reset && (o1_stb || o1_err)) begin
      if (q1.size() == 0) unexpected("u1", o1_stb, o1_err);
      else begin e = q1.pop_front(); judge("u1", o1_stb, o1_err, o1_data, k1, e); end
    end
  end

  always @(negedge clk_4f) begin : mon2
    exp_t e;
    if (!reset && (o2_stb || o2_err)) begin
      if (q2.size() == 0) unexpected("u2", o2_stb, o2_err);
      else begin e = q2.pop_front(); judge("u2", o2_stb, o2_err, o2_data, k2, e); end
    end
  end

  task automatic drv(input logic v, input logic [7:0] d);
    v0 = v;
    d0 = d;
    @(posedge clk_4f);
    #1;
  endtask

  task automatic drv2(input logic v, input logic [3:0] d);
    v2 = v;
    d2 = d;
    @(posedge clk_4f);
    #1;
  endtask

  task automatic push01(input logic is_err, input logic [31:0] w0, input logic [31:0] w1, input logic [7:0] keep);
    q0.push_back('{is_err, w0, keep});
    q1.push_back('{is_err, w1, keep});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] wm [3];
    logic [31:0] wl [3];
    logic [7:0]  b;

    reset = 1'b1; v0 = 1'b1; d0 = 8'h55; fl0 = 1'b0;
    v2 = 1'b0; d2 = 4'h0; fl2 = 1'b0;
    repeat (3) @(posedge clk_4f);
    #1;
    chk("rst_data0", o0_data, 32'h0);
    chk1("rst_stb0", o0_stb, 1'b0);
    chk1("rst_vld0", o0_vld, 1'b0);
    chk1("rst_err0", o0_err, 1'b0);
    chk("rst_data1", o1_data, 32'h0);
    chk("rst_data2", o2_data, 32'h0);
    chk("rst_keep0", {24'h0, k0}, 32'h0);
    reset = 1'b0;
    v0 = 1'b0;

    // Reset in the middle of a word: no error, next word clean.
    drv(1'b1, 8'h01);
    drv(1'b1, 8'h02);
    reset = 1'b1;
    drv(1'b0, 8'h00);
    reset = 1'b0;
    drv(1'b0, 8'h00);
    drv(1'b0, 8'h00);
    chk1("rst_mid_err", o0_err, 1'b0);
    push01(1'b0, 32'h10203040, 32'h40302010, 8'h0F);
    drv(1'b1, 8'h10); drv(1'b1, 8'h20); drv(1'b1, 8'h30); drv(1'b1, 8'h40);

    // DEADBEEF with latency check.
    push01(1'b0, 32'hDEADBEEF, 32'hEFBEADDE, 8'h0F);
    drv(1'b1, 8'hDE); drv(1'b1, 8'hAD); drv(1'b1, 8'hBE); drv(1'b1, 8'hEF);
    chk1("lat_early_stb", o0_stb, 1'b0);
    drv(1'b0, 8'h00);
    chk1("lat_stb", o0_stb, 1'b1);
    chk("lat_data0", o0_data, 32'hDEADBEEF);
    chk("lat_data1", o1_data, 32'hEFBEADDE);
    chk1("lat_vld", o0_vld, 1'b1);
    drv(1'b0, 8'h00);
    chk1("pulse_stb", o0_stb, 1'b0);
    chk("hold_data", o0_data, 32'hDEADBEEF);
    repeat (8) drv(1'b0, 8'h00);
    chk1("idle_vld", o0_vld, 1'b0);

    // Three back-to-back words.
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'hA0 + 8'(16 * w + k);
        wm[w][31 - 8 * k -: 8] = b;
        wl[w][8 * k +: 8] = b;
      end
      push01(1'b0, wm[w], wl[w], 8'h0F);
    end
    for (int i = 0; i < 12; i++) begin
      drv(1'b1, 8'hA0 + 8'(16 * (i / 4) + i % 4));
      if (i >= 1) chk1($sformatf("stream_stb_%0d", i), o0_stb, (i % 4) == 0);
      if (i >= 4) chk1($sformatf("stream_vld_%0d", i), o0_vld, 1'b1);
    end
    for (int j = 1; j <= 5; j++) begin
      drv(1'b0, 8'h00);
      if (j == 1) chk1("tail_stb", o0_stb, 1'b1);
      if (j == 4) chk1("tail_vld_hold", o0_vld, 1'b1);
      if (j == 5) chk1("tail_vld_drop", o0_vld, 1'b0);
    end

    // Partial word discarded.
    push01(1'b1, wm[2], wl[2], 8'h00);
    drv(1'b1, 8'h11); drv(1'b1, 8'h22); drv(1'b0, 8'h00);
    chk1("err_early", o0_err, 1'b0);
    drv(1'b0, 8'h00);
    chk1("err_pulse", o0_err, 1'b1);
    chk("err_hold0", o0_data, wm[2]);
    chk("err_hold1", o1_data, wl[2]);
    drv(1'b0, 8'h00);
    chk1("err_once", o0_err, 1'b0);
    push01(1'b0, 32'h01020304, 32'h04030201, 8'h0F);
    drv(1'b1, 8'h01); drv(1'b1, 8'h02); drv(1'b1, 8'h03); drv(1'b1, 8'h04);
    drv(1'b0, 8'h00); drv(1'b0, 8'h00);
    chk("after_err_word", o0_data, 32'h01020304);

`ifdef CONV_FLUSH_EN
    push01(1'b0, 32'hAABB0000, 32'h0000BBAA, 8'h03);
    drv(1'b1, 8'hAA); drv(1'b1, 8'hBB);
    fl0 = 1'b1;
    drv(1'b0, 8'h00);
    fl0 = 1'b0;
    drv(1'b0, 8'h00);
    chk1("flush_stb", o0_stb, 1'b1);
    chk("flush_data", o0_data, 32'hAABB0000);
    chk("flush_keep", {24'h0, k0}, 32'h3);
    chk1("flush_err", o0_err, 1'b0);
    drv(1'b0, 8'h00);
`endif

    // 4-bit x 8 instance.
    q2.push_back('{1'b0, 32'h12345678, 8'hFF});
    for (int k = 1; k <= 8; k++) drv2(1'b1, 4'(k));
    chk1("w4_early_stb", o2_stb, 1'b0);
    drv2(1'b0, 4'h0);
    chk1("w4_stb", o2_stb, 1'b1);
    chk("w4_data", o2_data, 32'h12345678);

    repeat (6) drv(1'b0, 8'h00);
    chk("q0_left", q0.size(), 32'h0);
    chk("q1_left", q1.size(), 32'h0);
    chk("q2_left", q2.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
